// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the serial pattern-detect arbiter.
package seq_detect_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: shifts one bit per enabled cycle into a history
// register and counts overlapping matches, saturating at all-ones.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_shift_en,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pattern,
    output logic [CNT_W-1:0] o_count
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0]  r_count;
    logic [PAT_W:0]    w_ext;
    logic [PAT_W-1:0]  w_hist_next;
    logic [FILL_W-1:0] w_fill_next;
    logic              w_match;

    // Next history/fill level and match decision for the incoming bit;
    // the extended vector keeps PAT_W=1 legal.
    always_comb begin
        w_ext       = {r_hist, i_bit};
        w_hist_next = w_ext[PAT_W-1:0];
        w_fill_next = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + FILL_W'(1);
        w_match     = i_shift_en && (w_fill_next == FILL_W'(PAT_W))
                      && (w_hist_next == i_pattern);
    end

    // History, fill level and saturating match count; cleared at each word start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
        end else if (i_shift_en) begin
            r_hist <= w_hist_next;
            r_fill <= w_fill_next;
            if (w_match && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_detect_arbiter.sv
// Two-requester arbiter feeding a serial pattern matcher.
// Define SEQ_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins);
// the default build uses round-robin between simultaneous requests.
//
// state  | meaning
// IDLE   | accept pattern load or grant one requester
// SHIFT  | feed the captured word MSB first, one bit per cycle
// REPORT | hold result until res_ready
module seq_detect_arbiter
    import seq_detect_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic [PAT_W-1:0]  pattern_in,
    input  logic              pattern_load,
    output logic              busy,
    output logic              res_valid,
    output logic              res_id,
    output logic [CNT_W-1:0]  res_count,
    input  logic              res_ready
);

    localparam int BCNT_W = $clog2(WORD_W + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WORD_W-1:0]  r_word;
    logic [BCNT_W-1:0]  r_bit_cnt;
    logic [PAT_W-1:0]   r_pattern;
    logic               r_id;
    logic               w_grant;
    logic               w_load;
    logic               w_shift_en;
    logic               w_win_id;
    logic               w_any_valid;
    logic [CNT_W-1:0]   w_count;
`ifndef SEQ_ARB_FIXED_PRIO_EN
    logic               r_prio;
`endif

    // Pick the winner among the offered requests.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
`ifdef SEQ_ARB_FIXED_PRIO_EN
        w_win_id = ~req0_valid;
`else
        w_win_id = (req0_valid && req1_valid) ? r_prio : ~req0_valid;
`endif
    end

    // State register.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and strobes; ready is masked during reset so outputs read 0.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_load       = 1'b0;
        w_shift_en   = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    if (pattern_load) begin
                        w_load = 1'b1;
                    end else if (w_any_valid) begin
                        w_grant      = 1'b1;
                        req0_ready   = ~w_win_id;
                        req1_ready   = w_win_id;
                        w_state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                if (r_bit_cnt == '0) begin
                    w_state_next = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Pattern register, word capture/shift, bit down-counter and arbitration history.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_word    <= '0;
            r_bit_cnt <= '0;
            r_pattern <= '0;
            r_id      <= 1'b0;
`ifndef SEQ_ARB_FIXED_PRIO_EN
            r_prio    <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_pattern <= pattern_in;
            end
            if (w_grant) begin
                r_word    <= w_win_id ? req1_data : req0_data;
                r_bit_cnt <= BCNT_W'(WORD_W - 1);
                r_id      <= w_win_id;
`ifndef SEQ_ARB_FIXED_PRIO_EN
                r_prio    <= ~w_win_id;
`endif
            end else if (w_shift_en) begin
                r_word    <= r_word << 1;
                r_bit_cnt <= r_bit_cnt - BCNT_W'(1);
            end
        end
    end

    seq_match_core #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_match (
        .i_clk      (Clk),
        .i_rst      (rst),
        .i_clear    (w_grant),
        .i_shift_en (w_shift_en),
        .i_bit      (r_word[WORD_W-1]),
        .i_pattern  (r_pattern),
        .o_count    (w_count)
    );

    assign busy      = (r_state != IDLE);
    assign res_valid = (r_state == REPORT);
    assign res_id    = r_id;
    assign res_count = w_count;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scoreboard bench for seq_detect_arbiter (default parameters).
module tb_seq_detect_arbiter;

    localparam int WORD_W = 8;

    logic       Clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready;
    logic [3:0] pattern_in = '0;
    logic       pattern_load = 1'b0;
    logic       busy, res_valid, res_id;
    logic [3:0] res_count;
    logic       res_ready = 1'b1;

    typedef struct packed {
        logic       id;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_grant_cyc = 0;
    logic prev_v = 1'b0;

    seq_detect_arbiter dut (
        .Clk          (Clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .pattern_in   (pattern_in),
        .pattern_load (pattern_load),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .res_count    (res_count),
        .res_ready    (res_ready)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic id, input logic [3:0] cnt);
        exp_t e;
        e.id  = id;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Offer one word and hold it until granted; reports extra cycles waited.
    task automatic drive_req(input int id, input logic [7:0] w, output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        @(posedge Clk); #1;
        if (id == 0) begin req0_valid = 1'b1; req0_data = w; end
        else         begin req1_valid = 1'b1; req1_data = w; end
        for (int k = 0; k < 300; k++) begin
            @(negedge Clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_timeout: req%0d never granted within 300 cycles", id);
        end
        @(posedge Clk); #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after 200 cycles");
        end
    endtask

    task automatic load_pattern(input logic [3:0] p);
        wait_idle();
        @(posedge Clk); #1;
        pattern_in   = p;
        pattern_load = 1'b1;
        @(posedge Clk); #1;
        pattern_load = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_res_valid"},  res_valid,  0);
        check({tag, "_res_id"},     res_id,     0);
        check({tag, "_res_count"},  res_count,  0);
        check({tag, "_req0_ready"}, req0_ready, 0);
        check({tag, "_req1_ready"}, req1_ready, 0);
    endtask

    // Monitor: grant timing, result latency and scoreboard comparison.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (req0_ready || req1_ready) begin
                    last_grant_cyc = cyc;
                    check("one_hot_ready", req0_ready & req1_ready, 0);
                end
                if (res_valid && !prev_v) begin
                    check("res_latency", cyc - last_grant_cyc, WORD_W + 1);
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_result: id=%0d count=%0d, none expected", res_id, res_count);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_id", res_id, e.id);
                        check("res_count", res_count, e.cnt);
                    end
                end
                prev_v = res_valid;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge Clk);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Pattern 1011, word 10110110 -> two overlapping matches
        load_pattern(4'b1011);
        push_exp(1'b0, 4'd2);
        drive_req(0, 8'b1011_0110, w);
        check("first_grant_wait", w, 0);

        // Pattern 1111: all-ones -> 5, all-zeros -> 0
        load_pattern(4'b1111);
        push_exp(1'b0, 4'd5);
        drive_req(0, 8'hFF, w);
        push_exp(1'b0, 4'd0);
        drive_req(0, 8'h00, w);

        // Consumer stall: result held, busy, no grant to a waiting requester
        load_pattern(4'b1011);
        wait_idle();
        res_ready = 1'b0;
        push_exp(1'b0, 4'd1);
        drive_req(0, 8'b0010_1100, w);
        req1_data  = 8'b1011_0110;
        req1_valid = 1'b1;
        push_exp(1'b1, 4'd2);
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (res_valid) break;
        end
        repeat (5) begin
            check("stall_valid", res_valid, 1);
            check("stall_id", res_id, 0);
            check("stall_count", res_count, 1);
            check("stall_busy", busy, 1);
            check("stall_req0_ready", req0_ready, 0);
            check("stall_req1_ready", req1_ready, 0);
            @(negedge Clk);
        end
        @(posedge Clk); #1;
        res_ready = 1'b1;
        drive_req(1, 8'b1011_0110, w);
        check("stall_release_grant_wait", w, 0);

        // Pattern load together with a request: load wins, grant next cycle
        wait_idle();
        @(posedge Clk); #1;
        pattern_in   = 4'b1111;
        pattern_load = 1'b1;
        req0_data    = 8'hFF;
        req0_valid   = 1'b1;
        push_exp(1'b0, 4'd5);
        @(negedge Clk);
        check("load_cycle_req0_ready", req0_ready, 0);
        check("load_cycle_busy", busy, 0);
        @(posedge Clk); #1;
        pattern_load = 1'b0;
        @(negedge Clk);
        check("after_load_req0_ready", req0_ready, 1);
        @(posedge Clk); #1;
        req0_valid = 1'b0;

        // Reset mid-SHIFT: outputs clear immediately, word abandoned
        wait_idle();
        drive_req(0, 8'hFF, w);
        repeat (6) @(posedge Clk);
        #1;
        check("mid_shift_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_shift_rst");
        @(posedge Clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge Clk);
        check("abandoned_no_result", exp_q.size(), 0);

        // Pattern register cleared by reset: pattern 0000 on all-zeros -> 5
        push_exp(1'b0, 4'd5);
        drive_req(0, 8'h00, w);

        // Arbitration order with both requesters busy, fresh from reset
        wait_idle();
        @(posedge Clk); #1;
        rst = 1'b1;
        @(posedge Clk); #1;
        rst = 1'b0;
        load_pattern(4'b1011);
`ifdef SEQ_ARB_FIXED_PRIO_EN
        push_exp(1'b0, 4'd2);
        push_exp(1'b0, 4'd1);
        push_exp(1'b1, 4'd0);
        push_exp(1'b1, 4'd1);
`else
        push_exp(1'b0, 4'd2);
        push_exp(1'b1, 4'd0);
        push_exp(1'b0, 4'd1);
        push_exp(1'b1, 4'd1);
`endif
        fork
            begin
                int w0;
                drive_req(0, 8'b1011_0110, w0);
                drive_req(0, 8'b0101_1000, w0);
            end
            begin
                int w1;
                drive_req(1, 8'h00, w1);
                drive_req(1, 8'b1011_0101, w1);
            end
        join
        wait_idle();
        repeat (3) @(posedge Clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 8: request word width in bits.
REQ-002 SHALL have parameter PAT_W, default 4: detection pattern width, 1 <= PAT_W <= WORD_W.
REQ-003 SHALL have parameter CNT_W, default 4: match count width.
REQ-004 SHALL have port Clk  input  1: single clock, rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have ports req0_valid, req1_valid  input  1: requester word offered.
REQ-007 SHALL have ports req0_data, req1_data  input  WORD_W: requester word.
REQ-008 SHALL have ports req0_ready, req1_ready  output  1: one-cycle grant/accept strobe.
REQ-009 SHALL have port pattern_in  input  PAT_W: pattern to program.
REQ-010 SHALL have port pattern_load  input  1: pattern write strobe.
REQ-011 SHALL have port busy  output  1: high in every state except IDLE.
REQ-012 SHALL have port res_valid  output  1: result available.
REQ-013 SHALL have port res_id  output  1: requester index of the result.
REQ-014 SHALL have port res_count  output  CNT_W: overlapping matches found in the word.
REQ-015 SHALL have port res_ready  input  1: result consumer accepts.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, REPORT.
REQ-017 In IDLE with pattern_load=1, SHALL latch pattern_in and grant no request that cycle.
REQ-018 pattern_load outside IDLE SHALL be ignored.
REQ-019 In IDLE with any valid and no pattern_load, SHALL assert the winner's ready for exactly that cycle, capture its data and id, and go to SHIFT.
REQ-020 If both requesters are valid, the grant SHALL go to the requester not granted last; after reset, requester 0 has priority.
REQ-021 In SHIFT, SHALL feed one bit per cycle, MSB first, for exactly WORD_W cycles, then go to REPORT.
REQ-022 Detector history SHALL clear at each word start, so no match spans two words.
REQ-023 A match SHALL count when at least PAT_W bits of the current word have been fed and the last PAT_W bits equal the pattern, overlapping allowed.
REQ-024 res_count SHALL saturate at 2^CNT_W-1.
REQ-025 If the grant is at cycle T, res_valid SHALL rise at T+WORD_W+1.
REQ-026 In REPORT, SHALL hold res_valid, res_id and res_count stable until res_ready=1, then return to IDLE on the next edge.
REQ-027 No ready SHALL be asserted outside IDLE; requesters hold valid and data until ready.

Reset
REQ-028 On rst, SHALL go to IDLE asynchronously.
REQ-029 On rst, SHALL clear all outputs to 0, clear the pattern register, and reset the round-robin pointer to favour requester 0.
REQ-030 On rst during SHIFT or REPORT, SHALL abandon the in-flight word with no result produced.

Configuration
REQ-031 With SEQ_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests and the round-robin pointer SHALL be omitted.
REQ-032 Without SEQ_ARB_FIXED_PRIO_EN, SHALL use round-robin per REQ-020.

Structure
REQ-033 The FSM state enum and default parameter constants SHALL reside in package seq_detect_pkg.
REQ-034 The serial pattern matcher (shift history, fill counter, compare, saturating counter) SHALL be sub-module seq_match_core, instantiated once.

Verification
REQ-035 Pattern 4'b1011, req0 word 8'b10110110 -> res_valid 9 cycles after grant, res_id=0, res_count=2.
REQ-036 Pattern 4'b1111, word 8'hFF -> res_count=5; word 8'h00 -> res_count=0.
REQ-037 Both valid on three consecutive words -> grants 0,1,0 (round-robin); with SEQ_ARB_FIXED_PRIO_EN -> grants 0,0,0.
REQ-038 res_ready held low for 5 cycles -> res_valid, res_id and res_count remain stable, busy=1, and no ready is asserted.
REQ-039 pattern_load and req0_valid asserted together in IDLE -> pattern loaded, req0_ready asserted the following cycle, and the result uses the new pattern.
REQ-040 rst asserted mid-SHIFT -> all outputs 0 immediately, and no res_valid is produced for the abandoned word.
